// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register and its operand forwarding.
package id_ex_stage_pkg;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_A   = 6'b011010;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NEQ = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_LTZ = 6'b111011;
    localparam logic [5:0] ALU_GTZ = 6'b111111;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        EX_LOAD   = 2'b00,
        EX_HOLD   = 2'b01,
        EX_BUBBLE = 2'b10
    } ex_action_e;

    // Flush beats an external stall, which beats a load-use bubble.
    function automatic ex_action_e ex_next_action(
        input logic flush,
        input logic stall,
        input logic load_use,
        input logic id_valid
    );
        if (flush)
            return EX_BUBBLE;
        if (stall)
            return EX_HOLD;
        if (load_use || !id_valid)
            return EX_BUBBLE;
        return EX_LOAD;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source operand forwarding: picks the youngest in-flight write to the EX source register.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          en,
    input  logic [RW-1:0] ex_addr,
    input  logic [DW-1:0] reg_val,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] fwd_val,
    output logic [1:0]    fwd_sel
);

    logic hit_mem;
    logic hit_wb;

    always_comb begin
        hit_mem = en && (ex_addr != '0) && exmem_reg_write && (exmem_rd == ex_addr);
        hit_wb  = en && (ex_addr != '0) && memwb_reg_write && (memwb_rd == ex_addr);
        fwd_sel = FWD_REG;
        fwd_val = reg_val;
        if (hit_mem) begin
            fwd_sel = FWD_MEM;
            fwd_val = exmem_result;
        end else if (hit_wb) begin
            fwd_sel = FWD_WB;
            fwd_val = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time write-through, EX-time forwarding to the ALU
// operands, and load-use bubble insertion with an upstream stall request.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_in,
    input  logic          flush_in,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic          id_alusrc_a,
    input  logic          id_alusrc_b,
    input  logic [5:0]    id_alufun,
    input  logic          id_sign,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [5:0]    alu_fun,
    output logic          alu_sign,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_valid,
    output logic          stall_req
);

    logic          ex_valid_q,     ex_valid_d;
    logic [RW-1:0] ex_rs_q,        ex_rs_d;
    logic [RW-1:0] ex_rt_q,        ex_rt_d;
    logic [RW-1:0] ex_rd_q,        ex_rd_d;
    logic [DW-1:0] ex_rs_data_q,   ex_rs_data_d;
    logic [DW-1:0] ex_rt_data_q,   ex_rt_data_d;
    logic [DW-1:0] ex_imm_q,       ex_imm_d;
    logic [4:0]    ex_shamt_q,     ex_shamt_d;
    logic          ex_alusrc_a_q,  ex_alusrc_a_d;
    logic          ex_alusrc_b_q,  ex_alusrc_b_d;
    logic [5:0]    ex_alufun_q,    ex_alufun_d;
    logic          ex_sign_q,      ex_sign_d;
    logic          ex_reg_write_q, ex_reg_write_d;
    logic          ex_mem_read_q,  ex_mem_read_d;
    logic          ex_mem_write_q, ex_mem_write_d;

    logic          load_use;
    ex_action_e    action;
    logic [DW-1:0] cap_rs_data;
    logic [DW-1:0] cap_rt_data;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic [1:0]    rs_sel;
    logic [1:0]    rt_sel;
    logic          unused_fwd_sel;

    // Conservative: a load hits on either source even if the consumer ignores rt.
    always_comb begin
        load_use = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) && id_valid &&
                   ((ex_rd_q == id_rs_addr) || (ex_rd_q == id_rt_addr));
        stall_req = load_use && !flush_in;
        action    = ex_next_action(flush_in, stall_in, load_use, id_valid);

        // Register file is written in the same cycle it is read; take the write-back value.
        cap_rs_data = id_rs_data;
        cap_rt_data = id_rt_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs_addr))
            cap_rs_data = memwb_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt_addr))
            cap_rt_data = memwb_data;
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_rd_d        = ex_rd_q;
        ex_rs_data_d   = ex_rs_data_q;
        ex_rt_data_d   = ex_rt_data_q;
        ex_imm_d       = ex_imm_q;
        ex_shamt_d     = ex_shamt_q;
        ex_alusrc_a_d  = ex_alusrc_a_q;
        ex_alusrc_b_d  = ex_alusrc_b_q;
        ex_alufun_d    = ex_alufun_q;
        ex_sign_d      = ex_sign_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_mem_write_d = ex_mem_write_q;
        case (action)
            EX_BUBBLE: begin
                ex_valid_d     = 1'b0;
                ex_rs_d        = '0;
                ex_rt_d        = '0;
                ex_rd_d        = '0;
                ex_rs_data_d   = '0;
                ex_rt_data_d   = '0;
                ex_imm_d       = '0;
                ex_shamt_d     = '0;
                ex_alusrc_a_d  = 1'b0;
                ex_alusrc_b_d  = 1'b0;
                ex_alufun_d    = '0;
                ex_sign_d      = 1'b0;
                ex_reg_write_d = 1'b0;
                ex_mem_read_d  = 1'b0;
                ex_mem_write_d = 1'b0;
            end
            EX_LOAD: begin
                ex_valid_d     = 1'b1;
                ex_rs_d        = id_rs_addr;
                ex_rt_d        = id_rt_addr;
                ex_rd_d        = id_rd_addr;
                ex_rs_data_d   = cap_rs_data;
                ex_rt_data_d   = cap_rt_data;
                ex_imm_d       = id_imm;
                ex_shamt_d     = id_shamt;
                ex_alusrc_a_d  = id_alusrc_a;
                ex_alusrc_b_d  = id_alusrc_b;
                ex_alufun_d    = id_alufun;
                ex_sign_d      = id_sign;
                ex_reg_write_d = id_reg_write;
                ex_mem_read_d  = id_mem_read;
                ex_mem_write_d = id_mem_write;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q     <= 1'b0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_shamt_q     <= '0;
            ex_alusrc_a_q  <= 1'b0;
            ex_alusrc_b_q  <= 1'b0;
            ex_alufun_q    <= '0;
            ex_sign_q      <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_rd_q        <= ex_rd_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_shamt_q     <= ex_shamt_d;
            ex_alusrc_a_q  <= ex_alusrc_a_d;
            ex_alusrc_b_q  <= ex_alusrc_b_d;
            ex_alufun_q    <= ex_alufun_d;
            ex_sign_q      <= ex_sign_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .en              (ex_valid_q),
        .ex_addr         (ex_rs_q),
        .reg_val         (ex_rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_val         (fwd_rs),
        .fwd_sel         (rs_sel)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .en              (ex_valid_q),
        .ex_addr         (ex_rt_q),
        .reg_val         (ex_rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_val         (fwd_rt),
        .fwd_sel         (rt_sel)
    );

    // The select codes are only of interest when probing the hierarchy.
    assign unused_fwd_sel = ^{rs_sel, rt_sel};

    assign alu_a         = ex_alusrc_a_q ? {{(DW-5){1'b0}}, ex_shamt_q} : fwd_rs;
    assign alu_b         = ex_alusrc_b_q ? ex_imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_fun       = ex_alufun_q;
    assign alu_sign      = ex_sign_q;
    assign ex_rd         = ex_rd_q;
    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_reg_write_q && ex_valid_q;
    assign ex_mem_read   = ex_mem_read_q && ex_valid_q;
    assign ex_mem_write  = ex_mem_write_q && ex_valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, a few multi-cycle sequences, then random traffic
// compared against a pipeline model built from in-flight write lists.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall_in, flush_in, id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic        id_alusrc_a, id_alusrc_b;
    logic [5:0]  id_alufun;
    logic        id_sign, id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, stall_req;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b), .id_alufun(id_alufun),
        .id_sign(id_sign), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_sign(alu_sign), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_valid(ex_valid), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt;
        logic        srca, srcb;
        logic [5:0]  fun;
        logic        sign, rw, mr, mw;
        logic        xm_rw;
        logic [4:0]  xm_rd;
        logic [31:0] xm_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] a, b, sd;
        logic        stall, valid, rw;
        logic [5:0]  fun;
    } vec_t;

    // Instruction sitting in EX as the model sees it.
    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh;
        logic        sa, sb;
        logic [5:0]  fun;
        logic        sg, rw, mr, mw;
    } ex_t;

    int n_tests;
    int n_fail;
    vec_t vecs[$];

    function automatic in_t idle();
        in_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic in_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] rsd,
                               input logic [31:0] rtd, input logic [31:0] imm, input logic sb,
                               input logic [5:0] fun, input logic rw, input logic mr,
                               input logic mw);
        in_t t;
        t = idle();
        t.valid = v; t.rs = rs; t.rt = rt; t.rd = rd; t.rs_data = rsd; t.rt_data = rtd;
        t.imm = imm; t.srcb = sb; t.fun = fun; t.rw = rw; t.mr = mr; t.mw = mw;
        return t;
    endfunction

    task automatic add_vec(input in_t t, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] sd, input logic st, input logic v, input logic rw,
                           input logic [5:0] fun);
        vec_t x;
        x.in = t; x.a = a; x.b = b; x.sd = sd; x.stall = st; x.valid = v; x.rw = rw; x.fun = fun;
        vecs.push_back(x);
    endtask

    task automatic drive(input in_t t);
        stall_in = t.stall; flush_in = t.flush; id_valid = t.valid;
        id_rs_addr = t.rs; id_rt_addr = t.rt; id_rd_addr = t.rd;
        id_rs_data = t.rs_data; id_rt_data = t.rt_data; id_imm = t.imm; id_shamt = t.shamt;
        id_alusrc_a = t.srca; id_alusrc_b = t.srcb; id_alufun = t.fun; id_sign = t.sign;
        id_reg_write = t.rw; id_mem_read = t.mr; id_mem_write = t.mw;
        exmem_reg_write = t.xm_rw; exmem_rd = t.xm_rd; exmem_result = t.xm_res;
        memwb_reg_write = t.wb_rw; memwb_rd = t.wb_rd; memwb_data = t.wb_data;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Value of register r as seen by EX: the youngest pending write wins, r0 is hardwired.
    function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] stale,
                                           input in_t i);
        logic        w_en[2];
        logic [4:0]  w_rd[2];
        logic [31:0] w_val[2];
        w_en[0] = i.xm_rw; w_rd[0] = i.xm_rd; w_val[0] = i.xm_res;
        w_en[1] = i.wb_rw; w_rd[1] = i.wb_rd; w_val[1] = i.wb_data;
        if (r == 5'd0)
            return stale;
        for (int k = 0; k < 2; k++)
            if (w_en[k] && w_rd[k] == r)
                return w_val[k];
        return stale;
    endfunction

    function automatic logic hazard(input ex_t s, input in_t i);
        return s.v && s.mr && s.rd != 5'd0 && i.valid && (s.rd == i.rs || s.rd == i.rt);
    endfunction

    function automatic ex_t step(input ex_t s, input in_t i);
        ex_t n;
        n = '{default: '0};
        if (i.flush)
            return n;
        if (i.stall)
            return s;
        if (hazard(s, i) || !i.valid)
            return n;
        n.v = 1'b1; n.rs = i.rs; n.rt = i.rt; n.rd = i.rd; n.imm = i.imm; n.sh = i.shamt;
        n.sa = i.srca; n.sb = i.srcb; n.fun = i.fun; n.sg = i.sign;
        n.rw = i.rw; n.mr = i.mr; n.mw = i.mw;
        n.rsd = (i.wb_rw && i.wb_rd != 5'd0 && i.wb_rd == i.rs) ? i.wb_data : i.rs_data;
        n.rtd = (i.wb_rw && i.wb_rd != 5'd0 && i.wb_rd == i.rt) ? i.wb_data : i.rt_data;
        return n;
    endfunction

    task automatic check_model(input ex_t s, input in_t i);
        logic [31:0] rsv, rtv;
        rsv = s.v ? newest(s.rs, s.rsd, i) : s.rsd;
        rtv = s.v ? newest(s.rt, s.rtd, i) : s.rtd;
        check("rnd_alu_a", alu_a, s.sa ? {27'd0, s.sh} : rsv);
        check("rnd_alu_b", alu_b, s.sb ? s.imm : rtv);
        check("rnd_store", ex_store_data, rtv);
        check("rnd_fun", 32'(alu_fun), 32'(s.fun));
        check("rnd_sign", 32'(alu_sign), 32'(s.sg));
        check("rnd_rd", 32'(ex_rd), 32'(s.rd));
        check("rnd_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
              {29'd0, s.v & s.rw, s.v & s.mr, s.v & s.mw});
        check("rnd_valid", 32'(ex_valid), 32'(s.v));
        check("rnd_stall", 32'(stall_req), 32'(hazard(s, i) && !i.flush));
    endtask

    initial begin
        in_t t;
        ex_t ms;
        n_tests = 0;
        n_fail  = 0;

        // c0: first instruction into an empty EX
        t = mk(1, 1, 2, 3, 32'h5, 32'h7, 0, 0, ALU_ADD, 1, 0, 0);
        add_vec(t, 0, 0, 0, 0, 0, 0, 6'd0);
        // c1: EX now shows c0's operands
        t = mk(1, 8, 0, 10, 32'h11, 0, 0, 0, ALU_SUB, 1, 0, 0);
        add_vec(t, 32'h5, 32'h7, 32'h7, 0, 1, 1, ALU_ADD);
        // c2: EX/MEM and MEM/WB both target rs=8; EX/MEM wins. Stall keeps EX.
        t = idle(); t.stall = 1; t.xm_rw = 1; t.xm_rd = 8; t.xm_res = 32'h12345678;
        t.wb_rw = 1; t.wb_rd = 8; t.wb_data = 32'hDEADBEEF;
        add_vec(t, 32'h12345678, 0, 0, 0, 1, 1, ALU_SUB);
        // c3: write to r0 must not forward into rt=0
        t = idle(); t.stall = 1; t.xm_rw = 1; t.xm_rd = 0; t.xm_res = 32'hFFFFFFFF;
        add_vec(t, 32'h11, 0, 0, 0, 1, 1, ALU_SUB);
        // c4: lw r9 enters
        t = mk(1, 1, 9, 9, 32'h100, 0, 32'h4, 1, ALU_ADD, 1, 1, 0);
        add_vec(t, 32'h11, 0, 0, 0, 1, 1, ALU_SUB);
        // c5: add uses r9 -> load-use
        t = mk(1, 9, 2, 3, 0, 32'h20, 0, 0, ALU_ADD, 1, 0, 0);
        add_vec(t, 32'h100, 32'h4, 0, 1, 1, 1, ALU_ADD);
        // c6: bubble in EX, add re-presented
        t.xm_rw = 1; t.xm_rd = 9; t.xm_res = 32'h104;
        add_vec(t, 0, 0, 0, 0, 0, 0, 6'd0);
        // c7: load data arrives on MEM/WB; next lw r12 enters
        t = mk(1, 0, 12, 12, 0, 32'h33, 32'h8, 1, ALU_ADD, 1, 1, 0);
        t.wb_rw = 1; t.wb_rd = 9; t.wb_data = 32'hCAFE;
        add_vec(t, 32'hCAFE, 32'h20, 32'h20, 0, 1, 1, ALU_ADD);
        // c8: flush + stall + load-use together: flush wins, no stall request
        t = mk(1, 12, 12, 13, 32'h1, 32'h2, 0, 0, ALU_SUB, 1, 0, 0);
        t.flush = 1; t.stall = 1;
        add_vec(t, 0, 32'h8, 32'h33, 0, 1, 1, ALU_ADD);
        // c9: EX is a bubble
        t.flush = 0; t.stall = 0;
        add_vec(t, 0, 0, 0, 0, 0, 0, 6'd0);
        // c10..c12: external stall holds SUB for three edges
        t = mk(1, 4, 5, 6, 32'h44, 32'h55, 0, 0, ALU_AND, 1, 0, 0);
        t.stall = 1;
        for (int k = 0; k < 3; k++)
            add_vec(t, 32'h1, 32'h2, 32'h2, 0, 1, 1, ALU_SUB);
        // c13: store with rt=4 captured through the write-back race
        t = mk(1, 0, 4, 0, 0, 32'h1, 0, 0, ALU_AND, 0, 0, 1);
        t.wb_rw = 1; t.wb_rd = 4; t.wb_data = 32'h0000ABCD;
        add_vec(t, 32'h1, 32'h2, 32'h2, 0, 1, 1, ALU_SUB);
        // c14, c15
        t = idle();
        add_vec(t, 0, 32'h0000ABCD, 32'h0000ABCD, 0, 1, 0, ALU_AND);
        add_vec(t, 0, 0, 0, 0, 0, 0, 6'd0);

        // Reset held with a live instruction on the ID side
        reset = 1'b0;
        drive(mk(1, 1, 2, 3, 32'h5, 32'h7, 32'h9, 1, ALU_ADD, 1, 1, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_regwr", 32'(ex_reg_write), 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].in);
            @(negedge clk);
            check($sformatf("v%0d_alu_a", k), alu_a, vecs[k].a);
            check($sformatf("v%0d_alu_b", k), alu_b, vecs[k].b);
            check($sformatf("v%0d_store", k), ex_store_data, vecs[k].sd);
            check($sformatf("v%0d_stall", k), 32'(stall_req), 32'(vecs[k].stall));
            check($sformatf("v%0d_valid", k), 32'(ex_valid), 32'(vecs[k].valid));
            check($sformatf("v%0d_regwr", k), 32'(ex_reg_write), 32'(vecs[k].rw));
            check($sformatf("v%0d_fun", k), 32'(alu_fun), 32'(vecs[k].fun));
            @(posedge clk);
            #1;
        end

        // External stall during load-use keeps the load and the request; then reset mid-cycle.
        drive(mk(1, 1, 9, 9, 32'h100, 0, 32'h4, 1, ALU_ADD, 1, 1, 0));
        @(posedge clk);
        #1;
        t = mk(1, 9, 2, 3, 0, 0, 0, 0, ALU_ADD, 1, 0, 0);
        t.stall = 1;
        drive(t);
        @(negedge clk);
        check("lu_stall_req", 32'(stall_req), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_stall_req", 32'(stall_req), 1);
        check("hold_valid", 32'(ex_valid), 1);
        check("hold_mem_read", 32'(ex_mem_read), 1);
        check("hold_alu_b", alu_b, 32'h4);
        #1 reset = 1'b0;
        #1;
        check("midrst_valid", 32'(ex_valid), 0);
        check("midrst_stall", 32'(stall_req), 0);
        check("midrst_alu_b", alu_b, 0);
        @(posedge clk);
        #1;
        check("midrst_hold", 32'(ex_valid), 0);
        reset = 1'b1;
        drive(idle());

        // Random traffic against the model; small register space to provoke hazards.
        ms = '{default: '0};
        for (int n = 0; n < 400; n++) begin
            t.stall   = ($urandom_range(0, 9) < 2);
            t.flush   = ($urandom_range(0, 9) < 1);
            t.valid   = ($urandom_range(0, 9) < 8);
            t.rs      = 5'($urandom_range(0, 7));
            t.rt      = 5'($urandom_range(0, 7));
            t.rd      = 5'($urandom_range(0, 7));
            t.rs_data = $urandom;
            t.rt_data = $urandom;
            t.imm     = $urandom;
            t.shamt   = 5'($urandom_range(0, 31));
            t.srca    = ($urandom_range(0, 9) < 3);
            t.srcb    = ($urandom_range(0, 9) < 4);
            t.fun     = 6'($urandom_range(0, 63));
            t.sign    = ($urandom_range(0, 1) == 1);
            t.rw      = ($urandom_range(0, 1) == 1);
            t.mr      = ($urandom_range(0, 9) < 3);
            t.mw      = ($urandom_range(0, 9) < 2);
            t.xm_rw   = ($urandom_range(0, 1) == 1);
            t.xm_rd   = 5'($urandom_range(0, 7));
            t.xm_res  = $urandom;
            t.wb_rw   = ($urandom_range(0, 1) == 1);
            t.wb_rd   = 5'($urandom_range(0, 7));
            t.wb_data = $urandom;
            drive(t);
            @(negedge clk);
            check_model(ms, t);
            ms = step(ms, t);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand forwarding for the execute stage.
- Captures decoded operands and control from decode and holds them for one stage.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then presents the final A/B operands, ALUFun and sign directly to the ALU inputs.
- Detects load-use hazards, inserts a bubble and requests an upstream stall.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- stall_in  in  1  external stall (memory busy); hold EX register
- flush_in  in  1  branch/jump flush; load bubble into EX
- id_valid  in  1  decode stage holds a real instruction
- id_rs_addr, id_rt_addr  in  RW  source register numbers
- id_rd_addr  in  RW  destination register number (already muxed rd/rt/31)
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  extended immediate
- id_shamt  in  5  shift amount
- id_alusrc_a  in  1  1: A = zero-extended shamt
- id_alusrc_b  in  1  1: B = imm
- id_alufun  in  6  ALU function code
- id_sign  in  1  signed compare/overflow select
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- exmem_reg_write  in  1  EX/MEM stage writes a register
- exmem_rd  in  RW  EX/MEM destination register
- exmem_result  in  DW  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB stage writes a register
- memwb_rd  in  RW  MEM/WB destination register
- memwb_data  in  DW  MEM/WB write-back data
- alu_a, alu_b  out  DW  ALU operands (combinational from EX register + forwarding)
- alu_fun  out  6  registered ALUFun
- alu_sign  out  1  registered sign
- ex_store_data  out  DW  forwarded rt value for stores
- ex_rd  out  RW  registered destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control, gated by ex_valid
- ex_valid  out  1  EX holds a real instruction
- stall_req  out  1  load-use stall request to PC/IF/ID (combinational)

Behaviour:
- Reset (reset=0, async): every EX register cleared to 0; ex_valid=0; all control outputs 0. After reset, alu_a/alu_b = 0 because forwarding matches are qualified by ex_valid.
- load_use = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs_addr | ex_rd==id_rt_addr). Matches on both rs and rt are deliberate and conservative.
- stall_req = load_use & ~flush_in.
- Register update priority on each rising clk edge:
  1. flush_in: bubble.
  2. stall_in: hold all EX registers.
  3. load_use: bubble.
  4. Otherwise: load from ID.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0; data fields = 0.
- Load with id_valid=0 is equivalent to a bubble.
- Capture-time write-through: on load, if memwb_reg_write & memwb_rd!=0 & memwb_rd==id_rs_addr, capture memwb_data instead of id_rs_data. Same rule for rt. This covers the register-file read/write race.
- Execute-time forwarding, per source (rs, rt):
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs: use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs: use memwb_data.
  - Else use the registered value.
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- alu_a = alusrc_a ? {27'b0, shamt} : fwd_rs.
- alu_b = alusrc_b ? imm : fwd_rt.
- ex_store_data = fwd_rt, independent of alusrc_b.
- Latency: one cycle from ID to EX register; forwarding adds zero cycles.
- Simultaneous events:
  - flush_in with load_use: flush wins; stall_req=0.
  - stall_in with load_use: hold (the load instruction stays in EX); stall_req stays 1.
- Reset asserted mid-stall or mid-bubble: immediate clear; no pending state survives.

Decomposition:
- Shared package holds:
  - ALUFun constants (ADD 000000, SUB 000001, AND 011000, SLL 100000, EQ 110011, ...).
  - Register-number constants: ZERO=0, RA=31.
  - Forward-select encoding: FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
- One natural sub-module: fwd_mux, instantiated twice (rs, rt).
  - Inputs: ex_addr, reg value, EX/MEM and MEM/WB write info.
  - Outputs: forwarded value and 2-bit select.

Test Plan:
- Reset: hold reset=0 with nonzero ID inputs, toggle clk -> ex_valid=0, ex_reg_write=0, alu_a=alu_b=0. Release -> first load shows id_rs_data=0x00000005 on alu_a.
- EX/MEM forward: EX rs=8; exmem_rd=8, reg_write=1, result=0x12345678 -> alu_a=0x12345678. Also memwb_rd=8, data=0xDEADBEEF -> alu_a still 0x12345678.
- Zero register: EX rt=0 with exmem_rd=0, reg_write=1, result=0xFFFFFFFF -> alu_b = registered rt value (0).
- Load-use: EX holds lw, rd=9; ID rs=9 -> stall_req=1. Next edge: ex_valid=0, ex_reg_write=0. Following cycle: stall_req=0; the add loads; memwb forward supplies the load data.
- Priority: flush_in=1, stall_in=1, load_use=1 same cycle -> stall_req=0; next edge EX is a bubble. Then stall_in=1 alone for 3 cycles -> EX fields unchanged (alu_fun=000001 stays).
- Write-through: load ID rt=4 while memwb_rd=4, memwb_reg_write=1, memwb_data=0x0000ABCD, id_rt_data=0x1 -> ex_store_data=0x0000ABCD after the edge, with no forwarding active.
